// File: rtl/otter_fetch_buffer_if.sv
// Bundles the fetch buffer's signals: the instruction-memory request and
// response, the redirect, and the decoder-facing output.
// The fetch buffer connects through 'master'; its environment uses 'slave'.
interface otter_fetch_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic              IMEM_REQ;
    logic [31:0]       IMEM_ADDR;
    logic              IMEM_RVALID;
    logic [31:0]       IMEM_RDATA;
    logic              REDIRECT;
    logic [31:0]       REDIRECT_PC;
    logic              OUT_READY;
    logic              OUT_VALID;
    logic [31:0]       OUT_PC;
    logic [31:0]       OUT_INSTR;
    logic [6:0]        OUT_OPCODE;
    logic [2:0]        OUT_FUNC3;
    logic [6:0]        OUT_FUNC7;
    logic [FILL_W-1:0] FILL_LEVEL;

    modport master (
        output IMEM_REQ, IMEM_ADDR,
        input  IMEM_RVALID, IMEM_RDATA,
        input  REDIRECT, REDIRECT_PC,
        input  OUT_READY,
        output OUT_VALID, OUT_PC, OUT_INSTR, OUT_OPCODE, OUT_FUNC3, OUT_FUNC7,
        output FILL_LEVEL
    );

    modport slave (
        input  IMEM_REQ, IMEM_ADDR,
        output IMEM_RVALID, IMEM_RDATA,
        output REDIRECT, REDIRECT_PC,
        output OUT_READY,
        input  OUT_VALID, OUT_PC, OUT_INSTR, OUT_OPCODE, OUT_FUNC3, OUT_FUNC7,
        input  FILL_LEVEL
    );
endinterface

// File: rtl/otter_fetch_buffer.sv
// OTTER instruction fetch buffer.
// Issues one word fetch at a time to instruction memory and queues the
// returned words, with their PCs, in an in-order FIFO for the decoder.
// A redirect empties the FIFO, restarts fetch at the new PC, and discards
// the response to any fetch that is still outstanding.
module otter_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  CLK,
    input  logic                  RST,
    otter_fetch_buffer_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT      = 2'd1,
        ST_WAIT_DROP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [31:0]        fetch_pc_r;
    logic [31:0]        fetch_pc_nxt_s;
    logic [31:0]        req_pc_r;
    logic [31:0]        req_pc_nxt_s;
    logic [31:0]        redirect_pc_s;

    logic [31:0]        fifo_pc_r    [DEPTH];
    logic [31:0]        fifo_instr_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic               empty_s;
    logic               full_s;
    logic               issue_s;
    logic               push_s;
    logic               pop_s;

    // Handshake qualifiers; reset and redirect suppress every FIFO and fetch action.
    always_comb begin
        empty_s       = (count_r == '0);
        full_s        = (count_r == CNT_W'(DEPTH));
        redirect_pc_s = bus.REDIRECT_PC & 32'hFFFF_FFFC;
        // Never issue into a full FIFO: the single outstanding response always has a slot.
        issue_s       = (state_r == ST_IDLE) && !RST && !bus.REDIRECT && !full_s;
        push_s        = (state_r == ST_WAIT) && bus.IMEM_RVALID && !RST && !bus.REDIRECT;
        pop_s         = !empty_s && bus.OUT_READY && !RST && !bus.REDIRECT;
    end

    // Fetch FSM next-state and fetch/request PC bookkeeping.
    always_comb begin
        state_nxt_s    = state_r;
        fetch_pc_nxt_s = fetch_pc_r;
        req_pc_nxt_s   = req_pc_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.REDIRECT) begin
                    fetch_pc_nxt_s = redirect_pc_s;
                end else if (issue_s) begin
                    req_pc_nxt_s   = fetch_pc_r;
                    fetch_pc_nxt_s = fetch_pc_r + 32'd4;
                    state_nxt_s    = ST_WAIT;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_WAIT, ST_WAIT_DROP: begin
                if (bus.REDIRECT) begin
                    fetch_pc_nxt_s = redirect_pc_s;
                end else begin
                    fetch_pc_nxt_s = fetch_pc_r;
                end
                // A response that lands with a redirect is consumed (and dropped) right away.
                if (bus.IMEM_RVALID) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.REDIRECT) begin
                    state_nxt_s = ST_WAIT_DROP;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and PC registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= RESET_PC;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            req_pc_r   <= req_pc_nxt_s;
        end
    end

    // FIFO pointers and occupancy; reset and redirect both empty the queue.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (bus.REDIRECT) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage: PC and instruction word of each returned fetch.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            fifo_pc_r[wr_ptr_r]    <= req_pc_r;
            fifo_instr_r[wr_ptr_r] <= bus.IMEM_RDATA;
        end
    end

    // Output drive: request from registered state, decoder fields from the head entry.
    always_comb begin
        bus.IMEM_REQ   = issue_s;
        bus.IMEM_ADDR  = fetch_pc_r;
        bus.FILL_LEVEL = count_r;
        bus.OUT_VALID  = !empty_s;
        if (!empty_s) begin
            bus.OUT_PC    = fifo_pc_r[rd_ptr_r];
            bus.OUT_INSTR = fifo_instr_r[rd_ptr_r];
        end else begin
            bus.OUT_PC    = 32'h0000_0000;
            bus.OUT_INSTR = 32'h0000_0000;
        end
        bus.OUT_OPCODE = bus.OUT_INSTR[6:0];
        bus.OUT_FUNC3  = bus.OUT_INSTR[14:12];
        bus.OUT_FUNC7  = bus.OUT_INSTR[31:25];
    end
endmodule

// File: tb/tb_otter_fetch_buffer.sv
// Testbench for otter_fetch_buffer: directed scenarios plus a randomized run
// checked cycle by cycle against a queue-based reference model.
module tb_otter_fetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic CLK;
    logic RST;

    otter_fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

    otter_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory responder state: at most one request in flight.
    bit          mem_mode;
    bit          rand_lat;
    int          lat;
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    bit          last_rv;

    // Reference model: fetch PC, outstanding flags, and a queue of {pc, instr}.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;
    entry_t      m_q[$];
    logic [31:0] m_fetch;
    logic [31:0] m_req_pc;
    bit          m_outst;
    bit          m_drop;

    logic        obs_req, exp_req;
    logic [31:0] obs_addr, exp_addr;
    logic        obs_valid, exp_valid;
    logic [31:0] obs_pc, exp_pc;
    logic [31:0] obs_instr, exp_instr;
    logic [6:0]  obs_opc, exp_opc;
    logic [2:0]  obs_f3, exp_f3;
    logic [6:0]  obs_f7, exp_f7;
    logic [$clog2(DEPTH):0] obs_fill, exp_fill;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (mem_mode) return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
        else          return 32'h0000_0013;
    endfunction

    // One clock cycle: drive inputs, sample outputs, advance model and memory.
    task automatic cycle(input bit rst_i, input bit redir_i, input logic [31:0] rpc_i, input bit ready_i);
        bit rv;
        @(negedge CLK);
        rv = mem_pend && (mem_cnt == 0);
        RST             = rst_i;
        bus.REDIRECT    = redir_i;
        bus.REDIRECT_PC = rpc_i;
        bus.OUT_READY   = ready_i;
        bus.IMEM_RVALID = rv;
        bus.IMEM_RDATA  = rv ? word_at(mem_addr) : $urandom();
        last_rv = rv;
        #1;
        obs_req   = bus.IMEM_REQ;
        obs_addr  = bus.IMEM_ADDR;
        obs_valid = bus.OUT_VALID;
        obs_pc    = bus.OUT_PC;
        obs_instr = bus.OUT_INSTR;
        obs_opc   = bus.OUT_OPCODE;
        obs_f3    = bus.OUT_FUNC3;
        obs_f7    = bus.OUT_FUNC7;
        obs_fill  = bus.FILL_LEVEL;
        exp_req   = !rst_i && !m_outst && !redir_i && (m_q.size() < DEPTH);
        exp_addr  = m_fetch;
        exp_valid = (m_q.size() > 0);
        if (exp_valid) begin
            exp_pc    = m_q[0].pc;
            exp_instr = m_q[0].instr;
        end else begin
            exp_pc    = 32'h0;
            exp_instr = 32'h0;
        end
        exp_opc  = exp_instr[6:0];
        exp_f3   = exp_instr[14:12];
        exp_f7   = exp_instr[31:25];
        exp_fill = ($clog2(DEPTH)+1)'(m_q.size());
        @(posedge CLK);
        if (rst_i) begin
            m_q.delete();
            m_fetch = RESET_PC;
            m_outst = 1'b0;
            m_drop  = 1'b0;
        end else if (redir_i) begin
            m_q.delete();
            m_fetch = rpc_i & 32'hFFFF_FFFC;
            if (m_outst && rv) begin
                m_outst = 1'b0;
                m_drop  = 1'b0;
            end else if (m_outst) begin
                m_drop = 1'b1;
            end
        end else begin
            if (m_q.size() > 0 && ready_i) void'(m_q.pop_front());
            if (m_outst && rv) begin
                if (!m_drop) m_q.push_back({m_req_pc, word_at(m_req_pc)});
                m_outst = 1'b0;
                m_drop  = 1'b0;
            end
            if (exp_req) begin
                m_req_pc = m_fetch;
                m_fetch  = m_fetch + 32'd4;
                m_outst  = 1'b1;
            end
        end
        if (rv) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (obs_req) begin
            mem_pend = 1'b1;
            mem_addr = obs_addr;
            mem_cnt  = (rand_lat ? int'($urandom_range(4, 1)) : lat) - 1;
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10 && mem_pend; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        mem_mode = 1'b0; lat = 1; rand_lat = 1'b0;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h40, 1'b1);
        n_cmp++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", obs_req); end
        n_cmp++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", obs_valid); end
        n_cmp++; if (obs_fill !== '0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", obs_fill); end
        n_cmp++; if ({obs_pc, obs_instr, obs_opc, obs_f3, obs_f7} !== 81'h0) begin
            n_fail++; $display("FAIL reset_out_zero: pc %h instr %h want 0", obs_pc, obs_instr); end
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++; if ({obs_req, obs_addr} !== {1'b1, RESET_PC}) begin
            n_fail++; $display("FAIL reset_first_fetch: req %b addr %h want 1 %h", obs_req, obs_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        logic [31:0] ea, ep;
        int last_req, nreq, npop;
        do_reset();
        mem_mode = 1'b0; lat = 1;
        ea = RESET_PC; ep = RESET_PC; last_req = -1; nreq = 0; npop = 0;
        for (int c = 0; c < 24; c++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            if (obs_req) begin
                n_cmp++; if (obs_addr !== ea) begin n_fail++; $display("FAIL stream_addr: got %h want %h", obs_addr, ea); end
                if (last_req >= 0) begin
                    n_cmp++; if (c - last_req != 2) begin n_fail++; $display("FAIL stream_gap: got %0d want 2", c - last_req); end
                end
                ea = ea + 32'd4; last_req = c; nreq++;
            end
            if (obs_valid) begin
                n_cmp++; if ({obs_pc, obs_opc, obs_f3, obs_f7} !== {ep, 7'h13, 3'h0, 7'h00}) begin
                    n_fail++; $display("FAIL stream_out: pc %h op %h f3 %h f7 %h want pc %h op 13 f3 0 f7 0", obs_pc, obs_opc, obs_f3, obs_f7, ep); end
                ep = ep + 32'd4; npop++;
            end
        end
        n_cmp++; if (nreq != 12) begin n_fail++; $display("FAIL stream_nreq: got %0d want 12", nreq); end
        n_cmp++; if (npop != 11) begin n_fail++; $display("FAIL stream_npop: got %0d want 11", npop); end
    endtask

    task automatic test_full();
        int nreq;
        do_reset();
        mem_mode = 1'b1; lat = 1; nreq = 0;
        for (int c = 0; c < 16; c++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            if (obs_req) nreq++;
        end
        n_cmp++; if (nreq != 4) begin n_fail++; $display("FAIL full_nreq: got %0d want 4", nreq); end
        n_cmp++; if ({obs_fill, obs_req} !== {3'd4, 1'b0}) begin
            n_fail++; $display("FAIL full_level: fill %0d req %b want 4 0", obs_fill, obs_req); end
        n_cmp++; if ({obs_pc, obs_instr} !== {32'h0, word_at(32'h0)}) begin
            n_fail++; $display("FAIL full_head: pc %h instr %h want 0 %h", obs_pc, obs_instr, word_at(32'h0)); end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++; if ({obs_fill, obs_req, obs_addr, obs_pc} !== {3'd3, 1'b1, 32'h10, 32'h4}) begin
            n_fail++; $display("FAIL full_after_pop: fill %0d req %b addr %h pc %h want 3 1 10 4", obs_fill, obs_req, obs_addr, obs_pc); end
        nreq = 0;
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            if (obs_req) nreq++;
        end
        n_cmp++; if ({nreq == 0, obs_fill} !== {1'b1, 3'd4}) begin
            n_fail++; $display("FAIL full_refill: extra req %0d fill %0d want 0 4", nreq, obs_fill); end
    endtask

    task automatic test_redirect_wait();
        bit found_req, found_out;
        do_reset();
        mem_mode = 1'b1; lat = 3;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++; if ({obs_req, obs_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL redir_pre_req: req %b addr %h want 1 0", obs_req, obs_addr); end
        cycle(1'b0, 1'b1, 32'h100, 1'b1);
        found_req = 1'b0; found_out = 1'b0;
        for (int c = 0; c < 20 && !found_out; c++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            if (c == 0) begin
                n_cmp++; if ({obs_fill, obs_valid} !== {3'd0, 1'b0}) begin
                    n_fail++; $display("FAIL redir_flush: fill %0d valid %b want 0 0", obs_fill, obs_valid); end
            end
            if (obs_req && !found_req) begin
                found_req = 1'b1;
                n_cmp++; if (obs_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got %h want 100", obs_addr); end
            end
            if (obs_valid) begin
                found_out = 1'b1;
                n_cmp++; if ({obs_pc, obs_instr} !== {32'h100, word_at(32'h100)}) begin
                    n_fail++; $display("FAIL redir_first_out: pc %h instr %h want 100 %h", obs_pc, obs_instr, word_at(32'h100)); end
            end
        end
        n_cmp++; if ({found_req, found_out} !== 2'b11) begin
            n_fail++; $display("FAIL redir_timeout: req/out seen %b want 11", {found_req, found_out}); end
    endtask

    task automatic test_redirect_rvalid();
        bit found_out;
        do_reset();
        mem_mode = 1'b1; lat = 2;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 10 && !(mem_pend && mem_cnt == 0); i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h203, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++; if ({obs_fill, obs_valid, obs_req, obs_addr} !== {3'd0, 1'b0, 1'b1, 32'h200}) begin
            n_fail++; $display("FAIL redir_rv: fill %0d valid %b req %b addr %h want 0 0 1 200", obs_fill, obs_valid, obs_req, obs_addr); end
        found_out = 1'b0;
        for (int c = 0; c < 10 && !found_out; c++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            if (obs_valid) begin
                found_out = 1'b1;
                n_cmp++; if (obs_pc !== 32'h200) begin n_fail++; $display("FAIL redir_rv_out: pc %h want 200", obs_pc); end
            end
        end
        n_cmp++; if (!found_out) begin n_fail++; $display("FAIL redir_rv_timeout: no output seen, want one"); end
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        int n;
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        do_reset();
        mem_mode = 1'b1; lat = 1;
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        n_cmp++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL wrap_redir_req: got %b want 0", obs_req); end
        n = 0;
        for (int c = 0; c < 12 && n < 3; c++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            if (obs_req) begin
                n_cmp++; if (obs_addr !== want[n]) begin n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", n, obs_addr, want[n]); end
                n++;
            end
        end
        n_cmp++; if (n != 3) begin n_fail++; $display("FAIL wrap_count: got %0d want 3", n); end
    endtask

    task automatic test_reset_outstanding();
        bit found, found_out;
        do_reset();
        mem_mode = 1'b1; lat = 3; found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            if (obs_req && obs_fill == 3'd2) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL rstout_setup: no request at fill 2, want one"); end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        n_cmp++; if ({obs_fill, obs_valid, obs_req} !== {3'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL rstout_flush: fill %0d valid %b req %b want 0 0 0", obs_fill, obs_valid, obs_req); end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++; if ({obs_req, obs_addr} !== {1'b1, RESET_PC}) begin
            n_fail++; $display("FAIL rstout_first_addr: req %b addr %h want 1 %h", obs_req, obs_addr, RESET_PC); end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++; if ({obs_fill, obs_valid} !== {3'd0, 1'b0}) begin
            n_fail++; $display("FAIL rstout_late_rv: fill %0d valid %b want 0 0", obs_fill, obs_valid); end
        found_out = 1'b0;
        for (int c = 0; c < 10 && !found_out; c++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            if (obs_valid) begin
                found_out = 1'b1;
                n_cmp++; if ({obs_pc, obs_instr} !== {RESET_PC, word_at(RESET_PC)}) begin
                    n_fail++; $display("FAIL rstout_out: pc %h instr %h want %h %h", obs_pc, obs_instr, RESET_PC, word_at(RESET_PC)); end
            end
        end
        n_cmp++; if (!found_out) begin n_fail++; $display("FAIL rstout_timeout: no output seen, want one"); end
    endtask

    task automatic test_random();
        bit redir, ready;
        int pct;
        do_reset();
        mem_mode = 1'b1; rand_lat = 1'b1;
        for (int c = 0; c < 800; c++) begin
            pct   = ((c / 100) % 2 == 0) ? 80 : 25;
            ready = ($urandom_range(99) < pct);
            redir = ($urandom_range(99) < 4);
            cycle(1'b0, redir, $urandom(), ready);
            n_cmp++;
            if ({obs_req, obs_req ? obs_addr : 32'h0, obs_valid, obs_pc, obs_instr, obs_opc, obs_f3, obs_f7, obs_fill} !==
                {exp_req, exp_req ? exp_addr : 32'h0, exp_valid, exp_pc, exp_instr, exp_opc, exp_f3, exp_f7, exp_fill}) begin
                n_fail++;
                $display("FAIL random_c%0d: req %b addr %h valid %b pc %h instr %h fill %0d | want req %b addr %h valid %b pc %h instr %h fill %0d",
                         c, obs_req, obs_addr, obs_valid, obs_pc, obs_instr, obs_fill,
                         exp_req, exp_addr, exp_valid, exp_pc, exp_instr, exp_fill);
            end
        end
        rand_lat = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        bus.REDIRECT = 1'b0; bus.REDIRECT_PC = 32'h0; bus.OUT_READY = 1'b0;
        bus.IMEM_RVALID = 1'b0; bus.IMEM_RDATA = 32'h0;
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'h0; last_rv = 1'b0;
        m_fetch = RESET_PC; m_req_pc = RESET_PC; m_outst = 1'b0; m_drop = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_outstanding();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
